load_store_unit: RTL and testbench

Core-side initiator for the single-ported `data_memory` block. It accepts one byte-addressed load or store from the execute stage per valid/ready handshake, drives the memory's word address, write data and write strobe, and captures the registered read data. It extracts and sign- or zero-extends sub-word load results and returns one response per request. Sub-word stores use read-modify-write when that feature is compiled in.

---
 rtl/tinker_lsu_pkg.sv | 22 ++
 rtl/lsu_byte_lane.sv | 46 ++++
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the byte-count helper used for alignment checks.
package tinker_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    RESP
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering: extracts and extends a load result from a
// memory word, and merges sub-word store data into a word at the same offset.
module lsu_byte_lane
  import tinker_lsu_pkg::*;
(
  input  logic [63:0] word_i,
  input  logic [2:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        is_signed_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] load_data_o,
  output logic [63:0] merge_data_o
);

  logic [5:0]  shamt;
  logic [63:0] lane;
  logic [63:0] size_mask;
  logic [63:0] lane_mask;

  assign shamt = {offset_i, 3'b000};
  assign lane  = word_i >> shamt;

  always_comb begin
    size_mask   = '1;
    load_data_o = lane;
    case (size_i)
      SZ_B: begin
        size_mask   = 64'h0000_0000_0000_00FF;
        load_data_o = {{56{is_signed_i & lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        size_mask   = 64'h0000_0000_0000_FFFF;
        load_data_o = {{48{is_signed_i & lane[15]}}, lane[15:0]};
      end
      SZ_W: begin
        size_mask   = 64'h0000_0000_FFFF_FFFF;
        load_data_o = {{32{is_signed_i & lane[31]}}, lane[31:0]};
      end
      default: ;
    endcase
  end

  assign lane_mask    = size_mask << shamt;
  assign merge_data_o = (word_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// Core-side initiator for the single-ported data memory: one request in
// flight. Define LSU_RMW_EN to enable read-modify-write for sub-word stores.
module load_store_unit
  import tinker_lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1025
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_control_signal,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic signed [63:0] mem_read_data
);

  localparam logic [60:0] MEM_WORDS_W = 61'(MEM_WORDS);

  lsu_state_e  state_q;
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        write_q;
  logic [63:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [63:0] resp_rdata_q;
  logic        mem_we_q;
  logic [63:0] mem_addr_q;
  logic [63:0] mem_wdata_q;

  logic        misaligned;
  logic        out_of_range;
  logic        no_rmw;
  logic        req_err;
  logic [63:0] load_data;
  logic [63:0] merge_data;

  assign misaligned   = |(req_addr[2:0] & 3'(size_bytes(req_size) - 4'd1));
  assign out_of_range = req_addr[63:3] >= MEM_WORDS_W;
`ifdef LSU_RMW_EN
  assign no_rmw = 1'b0;
`else
  // Without RMW a sub-word store would clobber the rest of the word.
  assign no_rmw = req_write && (req_size != SZ_D);
`endif
  assign req_err = misaligned || out_of_range || no_rmw;

  lsu_byte_lane u_lane (
    .word_i       (mem_read_data),
    .offset_i     (off_q),
    .size_i       (size_q),
    .is_signed_i  (signed_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      off_q        <= '0;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            off_q       <= req_addr[2:0];
            size_q      <= req_size;
            signed_q    <= req_signed;
            write_q     <= req_write;
            wdata_q     <= req_wdata;
            mem_addr_q  <= {3'b000, req_addr[63:3]};
            mem_wdata_q <= req_wdata;
            if (req_err) begin
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
              state_q      <= RESP;
            end else if (req_write && (req_size == SZ_D)) begin
              mem_we_q <= 1'b1;
              state_q  <= WR_ISSUE;
            end else begin
              state_q <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE: state_q <= RD_CAPTURE;
        RD_CAPTURE: begin
          if (write_q) begin
            mem_wdata_q <= merge_data;
            mem_we_q    <= 1'b1;
            state_q     <= WR_ISSUE;
          end else begin
            resp_rdata_q <= load_data;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        WR_ISSUE: begin
          mem_we_q     <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready          = req_ready_q;
  assign resp_valid         = resp_valid_q;
  assign resp_err           = resp_err_q;
  assign resp_rdata         = resp_rdata_q;
  assign mem_control_signal = mem_we_q;
  assign mem_address        = mem_addr_q;
  assign mem_write_data     = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural negedge-write,
// registered-read memory model.
module tb_load_store_unit;
  import tinker_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_control_signal;
  logic [63:0] mem_address;
  logic [63:0] mem_write_data;
  logic signed [63:0] mem_read_data = '0;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;

  logic [63:0] mem [0:1024];
  logic        poke_en = 1'b0;
  int          poke_idx = 0;
  logic [63:0] poke_data = '0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1025)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_write          (req_write),
    .req_size           (req_size),
    .req_signed         (req_signed),
    .req_addr           (req_addr),
    .req_wdata          (req_wdata),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_rdata         (resp_rdata),
    .resp_err           (resp_err),
    .mem_control_signal (mem_control_signal),
    .mem_address        (mem_address),
    .mem_write_data     (mem_write_data),
    .mem_read_data      (mem_read_data)
  );

  always @(negedge clk) begin
    if (poke_en) mem[poke_idx] = poke_data;
    else if (mem_control_signal && mem_address < 64'd1025) mem[mem_address[10:0]] = mem_write_data;
  end

  always @(posedge clk) begin
    if (mem_address < 64'd1025) mem_read_data <= mem[mem_address[10:0]];
    else mem_read_data <= '0;
  end

  always @(posedge mem_control_signal) we_cnt++;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [63:0] d);
    poke_idx = idx;
    poke_data = d;
    poke_en = 1'b1;
    @(negedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    req_write = v.wr;
    req_size = v.sz;
    req_signed = v.sg;
    req_addr = v.addr;
    req_wdata = v.wdata;
    req_valid = 1'b1;
  endtask

  // Latency counts the acceptance edge as 1; returns after the response handshake.
  task automatic run(input int id, input vec_t v);
    int lat;
    int we0;
    @(negedge clk);
    we0 = we_cnt;
    drive(v);
    chk($sformatf("v%0d req_ready", id), {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    $display("txn %0d wr=%0b sz=%0d addr=%h lat=%0d err=%0b rdata=%h", id, v.wr, v.sz, v.addr, lat, resp_err, resp_rdata);
    chk($sformatf("v%0d latency", id), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d resp_err", id), {63'd0, resp_err}, {63'd0, v.err});
    chk($sformatf("v%0d resp_rdata", id), resp_rdata, v.rdata);
    chk($sformatf("v%0d write_pulses", id), 64'(we_cnt - we0), (v.wr && !v.err) ? 64'd1 : 64'd0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d post resp_valid", id), {63'd0, resp_valid}, 64'd0);
    chk($sformatf("v%0d post req_ready", id), {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, SZ_D, 1'b0, 64'h10,   64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 2};
    vecs[1]  = '{1'b0, SZ_D, 1'b0, 64'h10,   64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 3};
    vecs[2]  = '{1'b0, SZ_B, 1'b1, 64'h1,    64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3};
    vecs[3]  = '{1'b0, SZ_B, 1'b0, 64'h1,    64'h0, 64'h80, 1'b0, 3};
    vecs[4]  = '{1'b0, SZ_H, 1'b1, 64'h0,    64'h0, 64'hFFFF_FFFF_FFFF_80FF, 1'b0, 3};
    vecs[5]  = '{1'b0, SZ_W, 1'b0, 64'h14,   64'h0, 64'h0000_0000_DEAD_BEEF, 1'b0, 3};
    vecs[6]  = '{1'b0, SZ_W, 1'b1, 64'h14,   64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0, 3};
    vecs[7]  = '{1'b0, SZ_H, 1'b0, 64'h3,    64'h0, 64'h0, 1'b1, 1};
    vecs[8]  = '{1'b0, SZ_D, 1'b0, 64'h2008, 64'h0, 64'h0, 1'b1, 1};
    vecs[9]  = '{1'b0, SZ_D, 1'b0, 64'h2000, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 3};
    vecs[10] = '{1'b1, SZ_W, 1'b0, 64'h12,   64'h12345678, 64'h0, 1'b1, 1};
`ifdef LSU_RMW_EN
    vecs[11] = '{1'b1, SZ_H, 1'b0, 64'h1A,   64'hABCD, 64'h0, 1'b0, 4};
    vecs[12] = '{1'b0, SZ_D, 1'b0, 64'h18,   64'h0, 64'h1111_1111_ABCD_1111, 1'b0, 3};
`else
    vecs[11] = '{1'b1, SZ_B, 1'b0, 64'h18,   64'h55, 64'h0, 1'b1, 1};
    vecs[12] = '{1'b0, SZ_D, 1'b0, 64'h18,   64'h0, 64'h1111_1111_1111_1111, 1'b0, 3};
`endif
    vecs[13] = '{1'b0, SZ_D, 1'b1, 64'h10,   64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 3};

    poke(0, 64'h0000_0000_0000_80FF);
    poke(3, 64'h1111_1111_1111_1111);
    poke(4, 64'h7777_7777_7777_7777);
    poke(1024, 64'h0123_4567_89AB_CDEF);

    chk("rst resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst resp_err", {63'd0, resp_err}, 64'd0);
    chk("rst resp_rdata", resp_rdata, 64'd0);
    chk("rst mem_we", {63'd0, mem_control_signal}, 64'd0);
    chk("rst mem_address", mem_address, 64'd0);
    chk("rst mem_write_data", mem_write_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst req_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < NV; i++) begin
      run(i, vecs[i]);
      if (i == 0) chk("mem word2 after dword store", mem[2], 64'hDEADBEEF_CAFEF00D);
    end
`ifdef LSU_RMW_EN
    chk("mem word3 after rmw", mem[3], 64'h1111_1111_ABCD_1111);
`else
    chk("mem word3 untouched", mem[3], 64'h1111_1111_1111_1111);
`endif

    // Backpressure with a queued request behind the stalled response.
    begin
      int lat;
      @(negedge clk);
      resp_ready = 1'b0;
      drive(vecs[1]);
      @(posedge clk);
      #1;
      drive(vecs[3]);
      lat = 1;
      while (!resp_valid && lat < 10) begin
        @(posedge clk);
        #1 lat++;
      end
      chk("bp latency", 64'(lat), 64'd3);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        chk("bp resp_valid held", {63'd0, resp_valid}, 64'd1);
        chk("bp resp_rdata held", resp_rdata, 64'hDEADBEEF_CAFEF00D);
        chk("bp req_ready low", {63'd0, req_ready}, 64'd0);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp after hs resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("bp queued not yet taken", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("bp queued accepted", {63'd0, req_ready}, 64'd0);
      lat = 1;
      while (!resp_valid && lat < 10) begin
        @(posedge clk);
        #1 lat++;
      end
      $display("txn bp-queued lat=%0d rdata=%h", lat, resp_rdata);
      chk("bp queued latency", 64'(lat), 64'd3);
      chk("bp queued rdata", resp_rdata, 64'h80);
      @(posedge clk);
      #1;
    end

    // Reset while the FSM sits in RD_CAPTURE.
    begin
      vec_t rv;
      int we0;
`ifdef LSU_RMW_EN
      rv = '{1'b1, SZ_B, 1'b0, 64'h20, 64'h55, 64'h0, 1'b0, 4};
`else
      rv = '{1'b0, SZ_D, 1'b0, 64'h20, 64'h0, 64'h0, 1'b0, 3};
`endif
      @(negedge clk);
      we0 = we_cnt;
      drive(rv);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid-rst resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("mid-rst resp_err", {63'd0, resp_err}, 64'd0);
      chk("mid-rst resp_rdata", resp_rdata, 64'd0);
      chk("mid-rst mem_we", {63'd0, mem_control_signal}, 64'd0);
      chk("mid-rst mem_address", mem_address, 64'd0);
      chk("mid-rst mem_write_data", mem_write_data, 64'd0);
      chk("mid-rst req_ready", {63'd0, req_ready}, 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      $display("txn mid-reset addr=%h word4=%h", rv.addr, mem[4]);
      chk("mid-rst word4 unchanged", mem[4], 64'h7777_7777_7777_7777);
      chk("mid-rst no write pulse", 64'(we_cnt - we0), 64'd0);
      run(100, vecs[3]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
